// File: rtl/sitcp_cmd_pkg.sv
// Shared constants and types for the SiTCP RX command decoder.
package sitcp_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] OP_WR     = 8'h01;
  localparam logic [7:0] OP_RD     = 8'h02;

  // Sync, opcode, address, four data bytes, checksum.
  localparam int unsigned FRAME_LEN = 8;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_CSUM = 2'b01,
    ST_OPC  = 2'b10,
    ST_TMO  = 2'b11
  } rsp_status_t;

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    ADR,
    DAT,
    CSUM,
    EXEC,
    WAIT,
    RESP
  } cmd_state_t;

  // States in which the parser is allowed to consume FIFO bytes.
  function automatic logic is_parse_state(input cmd_state_t s);
    return (s == IDLE) || (s == OPC) || (s == ADR) || (s == DAT) || (s == CSUM);
  endfunction

endpackage

// File: rtl/sitcp_rx_byte_fifo.sv
// First-word-fall-through byte FIFO with occupancy count and synchronous flush.
module sitcp_rx_byte_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign pop     = rd_en && !empty;
  // A pop in the same cycle frees a slot, so a write at full is still taken.
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Byte storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sitcp_rx_cmd_decoder.sv
// Decodes 8-byte SiTCP RX command frames into register-bus accesses and
// returns one response word per frame.
module sitcp_rx_cmd_decoder
  import sitcp_cmd_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
  input  logic        CLK_200M,
  input  logic        SYS_RSTn,
  input  logic        TCP_OPEN_ACK,
  input  logic        TCP_RX_WR,
  input  logic [7:0]  TCP_RX_DATA,
  output logic [15:0] TCP_RX_WC,
  output logic        REG_WE,
  output logic        REG_RE,
  output logic [7:0]  REG_ADDR,
  output logic [31:0] REG_WD,
  input  logic [31:0] REG_RD,
  input  logic        REG_ACK,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_DATA,
  output logic [1:0]  RSP_STATUS,
  output logic        OVF,
  output logic [15:0] ERR_CNT
);

  localparam logic [1:0] DAT_LAST = 2'(FRAME_LEN - 5);

  logic               flush;
  logic               fifo_empty;
  logic               fifo_full;
  logic [7:0]         fifo_rd_data;
  logic [FIFO_AW:0]   fifo_count;
  logic               pop;
  logic               drop;
  logic               op_valid;
  logic               csum_bad;
  logic               tmo_hit;
  logic               frame_err;

  cmd_state_t         state;
  logic [7:0]         op;
  logic [7:0]         addr;
  logic [31:0]        wdata;
  logic [7:0]         csum;
  logic [1:0]         dat_cnt;
  logic [15:0]        tmo_cnt;
  logic               reg_we;
  logic               reg_re;
  logic               rsp_valid;
  logic [31:0]        rsp_data;
  rsp_status_t        rsp_status;
  logic               ovf;
  logic [15:0]        err_cnt;
  logic [1:0]         err_inc;
  logic [16:0]        err_sum;

  assign flush = !TCP_OPEN_ACK;

  sitcp_rx_byte_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (CLK_200M),
    .rst_n   (SYS_RSTn),
    .flush   (flush),
    .wr_en   (TCP_RX_WR),
    .wr_data (TCP_RX_DATA),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign TCP_RX_WC  = {{(15 - FIFO_AW){1'b1}}, fifo_count};
  assign REG_WE     = reg_we;
  assign REG_RE     = reg_re;
  assign REG_ADDR   = addr;
  assign REG_WD     = wdata;
  assign RSP_VALID  = rsp_valid;
  assign RSP_DATA   = rsp_data;
  assign RSP_STATUS = rsp_status;
  assign OVF        = ovf;
  assign ERR_CNT    = err_cnt;

  // Pop control, drop detection and error-event decode shared by the FSM and counters.
  always_comb begin
    pop       = TCP_OPEN_ACK && !fifo_empty && is_parse_state(state);
    drop      = TCP_OPEN_ACK && TCP_RX_WR && fifo_full && !pop;
    op_valid  = (op == OP_WR) || (op == OP_RD);
    csum_bad  = (fifo_rd_data != csum);
    tmo_hit   = (tmo_cnt >= ACK_TIMEOUT - 16'd1);
    frame_err = 1'b0;
    if (TCP_OPEN_ACK) begin
      if (state == CSUM && pop)
        frame_err = csum_bad || !op_valid;
      else if (state == WAIT && !REG_ACK && tmo_hit)
        frame_err = 1'b1;
    end
    err_inc = {1'b0, drop} + {1'b0, frame_err};
    err_sum = {1'b0, err_cnt} + {15'd0, err_inc};
  end

  // Frame parser, register-bus sequencing and response holding.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state      <= IDLE;
      op         <= '0;
      addr       <= '0;
      wdata      <= '0;
      csum       <= '0;
      dat_cnt    <= '0;
      tmo_cnt    <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
    end else if (!TCP_OPEN_ACK) begin
      state     <= IDLE;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      case (state)
        IDLE: begin
          if (pop && fifo_rd_data == SYNC_BYTE) state <= OPC;
        end
        OPC: begin
          if (pop) begin
            op    <= fifo_rd_data;
            csum  <= fifo_rd_data;
            state <= ADR;
          end
        end
        ADR: begin
          if (pop) begin
            addr    <= fifo_rd_data;
            csum    <= csum ^ fifo_rd_data;
            dat_cnt <= '0;
            state   <= DAT;
          end
        end
        DAT: begin
          if (pop) begin
            wdata   <= {wdata[23:0], fifo_rd_data};
            csum    <= csum ^ fifo_rd_data;
            dat_cnt <= dat_cnt + 2'd1;
            if (dat_cnt == DAT_LAST) state <= CSUM;
          end
        end
        CSUM: begin
          if (pop) begin
            if (csum_bad) begin
              rsp_status <= ST_CSUM;
              rsp_data   <= '0;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else if (!op_valid) begin
              rsp_status <= ST_OPC;
              rsp_data   <= '0;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              reg_we  <= (op == OP_WR);
              reg_re  <= (op == OP_RD);
              tmo_cnt <= '0;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          // The strobe cycle counts as cycle 0 of the acknowledge wait.
          tmo_cnt <= tmo_cnt + 16'd1;
          state   <= WAIT;
        end
        WAIT: begin
          if (REG_ACK) begin
            rsp_data   <= (op == OP_RD) ? REG_RD : wdata;
            rsp_status <= ST_OK;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (tmo_hit) begin
            rsp_data   <= '0;
            rsp_status <= ST_TMO;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow flag and saturating error counter; survive connection close.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      ovf     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (drop) ovf <= 1'b1;
      err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
    end
  end

endmodule
